da_shift_acc: RTL and testbench

- Bit-serial shift-accumulate stage directly downstream of the distributed-arithmetic LUT (offset-binary-coded).
- Consumes one signed LUT partial sum per activation bit-plane, LSB plane first, over DATA_WIDTH_A planes.
- Applies the two's-complement MSB subtraction and the OBC offset correction, then holds the full dot-product result for a valid/ready consumer (requant/output buffer).

---
 rtl/da_pkg.sv | 24 ++
 rtl/da_plane_shift.sv | 25 ++
 rtl/da_shift_acc.sv | 104 ++++++++++
 tb/tb_da_shift_acc.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic datapath: FSM states,
// default operand sizes and the width helpers used by the LUT, address and accumulate stages.
package da_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam int DEF_DATA_WIDTH_A = 8;
  localparam int DEF_DATA_WIDTH_B = 8;
  localparam int DEF_K            = 4;

  // Magnitude width of one LUT partial sum; the signed value carries one extra bit.
  function automatic int lut_width(input int data_width_b, input int k);
    return data_width_b + $clog2(k);
  endfunction

  function automatic int acc_width(input int lut_w, input int data_width_a);
    return lut_w + data_width_a + 2;
  endfunction

endpackage

// File: rtl/da_plane_shift.sv
// Weights one LUT partial sum by its bit-plane position; the MSB plane is negated
// because the activation is two's complement. Purely combinational so it can be retimed later.
module da_plane_shift
  import da_pkg::*;
#(
  parameter int LUT_WIDTH = 10,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_W     = 3
) (
  input  logic signed [LUT_WIDTH:0]   i_lut,
  input  logic        [CNT_W-1:0]     i_shamt,
  input  logic                        i_is_msb,
  output logic signed [ACC_WIDTH-1:0] o_term
);

  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_shift;

  always_comb begin
    w_ext   = {{(ACC_WIDTH-LUT_WIDTH-1){i_lut[LUT_WIDTH]}}, i_lut};
    w_shift = w_ext <<< i_shamt;
    o_term  = i_is_msb ? -w_shift : w_shift;
  end

endmodule

// File: rtl/da_shift_acc.sv
// Bit-serial shift-accumulate behind the OBC distributed-arithmetic LUT: folds one partial
// sum per activation bit-plane (LSB first), applies the offset on the MSB plane and holds the result.
module da_shift_acc
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = DEF_DATA_WIDTH_A,
  parameter int DATA_WIDTH_B = DEF_DATA_WIDTH_B,
  parameter int K            = DEF_K,
  parameter int LUT_WIDTH    = lut_width(DATA_WIDTH_B, K),
  parameter int ACC_WIDTH    = acc_width(LUT_WIDTH, DATA_WIDTH_A)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] offset_in,
  input  logic                        lut_valid,
  input  logic signed [LUT_WIDTH:0]   lut_in,
  output logic                        busy,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int CNT_W = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(DATA_WIDTH_A - 1);

  fsm_e                        r_state;
  fsm_e                        w_next;
  logic        [CNT_W-1:0]     r_bit_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_offset;
  logic signed [ACC_WIDTH-1:0] r_acc_out;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic                        w_is_msb;
  logic                        w_plane;
  logic                        w_hs;
  logic                        w_load;

  assign w_is_msb = (r_bit_cnt == LAST_PLANE);
  assign w_plane  = (r_state == ACCUM) && lut_valid;
  assign w_hs     = (r_state == DONE) && out_ready;
  // A start landing on the result handshake chains straight into the next dot product.
  assign w_load   = start && ((r_state == IDLE) || w_hs);

  da_plane_shift #(
    .LUT_WIDTH (LUT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_W     (CNT_W)
  ) u_plane_shift (
    .i_lut    (lut_in),
    .i_shamt  (r_bit_cnt),
    .i_is_msb (w_is_msb),
    .o_term   (w_term)
  );

  assign w_acc_next = r_acc + w_term + (w_is_msb ? r_offset : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_plane && w_is_msb) w_next = DONE;
      DONE:    if (w_hs) w_next = start ? ACCUM : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == ACCUM);
    out_valid = (r_state == DONE);
    acc_out   = r_acc_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_offset  <= '0;
      r_acc_out <= '0;
    end else if (w_load) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_offset  <= offset_in;
    end else if (w_plane) begin
      r_acc <= w_acc_next;
      if (w_is_msb) begin
        r_acc_out <= w_acc_next;
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_da_shift_acc.sv
// Bench for da_shift_acc: golden dot-product model feeding a result queue, directed
// scenarios for latency, stalls, backpressure, restart and reset, plus a 1-plane build.
module tb_da_shift_acc;

  localparam int WA  = 8;
  localparam int WB  = 8;
  localparam int KK  = 4;
  localparam int LW  = WB + $clog2(KK);
  localparam int AW  = LW + WA + 2;
  localparam int AW1 = LW + 1 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, lut_valid, out_ready, busy, out_valid;
  logic signed [AW-1:0] offset_in, acc_out;
  logic signed [LW:0]   lut_in;

  logic                  start_1, lut_valid_1, out_ready_1, busy_1, out_valid_1;
  logic signed [AW1-1:0] offset_in_1, acc_out_1;
  logic signed [LW:0]    lut_in_1;

  da_shift_acc #(.DATA_WIDTH_A(WA), .DATA_WIDTH_B(WB), .K(KK)) u_dut (
    .clk(clk), .rst(rst), .start(start), .offset_in(offset_in),
    .lut_valid(lut_valid), .lut_in(lut_in), .busy(busy),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  da_shift_acc #(.DATA_WIDTH_A(1), .DATA_WIDTH_B(WB), .K(KK)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_1), .offset_in(offset_in_1),
    .lut_valid(lut_valid_1), .lut_in(lut_in_1), .busy(busy_1),
    .acc_out(acc_out_1), .out_valid(out_valid_1), .out_ready(out_ready_1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                 va[KK];
  int                 vb[KK];
  logic signed [LW:0] planes[WA];
  logic signed [AW-1:0] offs;
  int                 exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // OBC model: plane j sums +-B_k/2 by activation bit j; result is the plain dot product.
  task automatic prep();
    int s, o, e;
    o = 0;
    e = 0;
    for (int k = 0; k < KK; k++) begin
      o -= vb[k] / 2;
      e += va[k] * vb[k];
    end
    for (int j = 0; j < WA; j++) begin
      s = 0;
      for (int k = 0; k < KK; k++) s += va[k][j] ? (vb[k] / 2) : -(vb[k] / 2);
      planes[j] = s[LW:0];
    end
    offs = o[AW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3);
    va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
    vb[0] = 2;  vb[1] = 4;  vb[2] = 6;  vb[3] = 8;
  endtask

  task automatic do_start();
    start     = 1'b1;
    offset_in = offs;
    step();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic feed(input int gap2, input int gap6, input bit poke, input int nplanes, input int rgap);
    for (int j = 0; j < nplanes; j++) begin
      if (j == 3) repeat (gap2) begin lut_valid = 1'b0; step(); end
      if (j == 7) repeat (gap6) begin lut_valid = 1'b0; step(); end
      if (rgap > 0) repeat ($urandom_range(rgap)) begin lut_valid = 1'b0; step(); end
      lut_valid = 1'b1;
      lut_in    = planes[j];
      if (poke && j == 2) begin
        start     = 1'b1;
        offset_in = AW'(12345);
      end
      step();
      start = 1'b0;
    end
    lut_valid = 1'b0;
    lut_in    = '0;
  endtask

  task automatic wait_valid(output int lat, output bit to);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    to  = (out_valid !== 1'b1);
    lat = cyc - t0 + 1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_checks += 3;
    if (acc_out !== '0) begin n_errors++; $display("FAIL reset_acc_out: got %0d want 0", acc_out); end
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat, e;
    bit to;
    set_vec(1, 1, 1, 1);
    prep();
    do_start();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    feed(0, 0, 1'b0, WA, 0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks += 3;
    if (to) begin n_errors++; $display("FAIL basic_timeout: out_valid never rose"); end
    if (lat != WA + 1) begin n_errors++; $display("FAIL basic_latency: got %0d want %0d", lat, WA + 1); end
    if (acc_out !== AW'(e)) begin n_errors++; $display("FAIL basic_value: got %0d want %0d", acc_out, e); end
    handshake();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_negative();
    int lat, e;
    bit to;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_vec(-1, -1, -1, -1);
      else set_vec(-128, -128, -128, -128);
      prep();
      do_start();
      feed(0, 0, 1'b0, WA, 0);
      wait_valid(lat, to);
      e = exp_q.pop_front();
      n_checks += 2;
      if (to) begin n_errors++; $display("FAIL neg_timeout[%0d]: out_valid never rose", t); end
      if (acc_out !== AW'(e)) begin n_errors++; $display("FAIL neg_value[%0d]: got %0d want %0d", t, acc_out, e); end
      handshake();
    end
  endtask

  task automatic test_stall();
    int lat, e;
    bit to;
    set_vec(1, 1, 1, 1);
    prep();
    do_start();
    feed(3, 3, 1'b0, WA, 0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks += 3;
    if (to) begin n_errors++; $display("FAIL stall_timeout: out_valid never rose"); end
    if (lat != WA + 1 + 6) begin n_errors++; $display("FAIL stall_latency: got %0d want %0d", lat, WA + 7); end
    if (acc_out !== AW'(e)) begin n_errors++; $display("FAIL stall_value: got %0d want %0d", acc_out, e); end
    handshake();
  endtask

  task automatic test_backpressure_restart();
    int lat, e;
    bit to;
    set_vec(1, 1, 1, 1);
    prep();
    do_start();
    feed(0, 0, 1'b1, WA, 0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to) begin n_errors++; $display("FAIL bp_timeout: out_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      if (acc_out !== AW'(e)) begin n_errors++; $display("FAIL bp_hold_value[%0d]: got %0d want %0d", i, acc_out, e); end
    end
    set_vec(-1, -1, -1, -1);
    prep();
    start     = 1'b1;
    offset_in = offs;
    out_ready = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    t0        = cyc;
    n_checks += 2;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL restart_busy: got %b want 1", busy); end
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL restart_valid: got %b want 0", out_valid); end
    feed(0, 0, 1'b0, WA, 0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks += 2;
    if (to || lat != WA + 1) begin n_errors++; $display("FAIL restart_latency: got %0d want %0d", lat, WA + 1); end
    if (acc_out !== AW'(e)) begin n_errors++; $display("FAIL restart_value: got %0d want %0d", acc_out, e); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat, e;
    bit to;
    set_vec(1, 1, 1, 1);
    prep();
    do_start();
    feed(0, 0, 1'b0, 5, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    n_checks += 3;
    if (acc_out !== '0) begin n_errors++; $display("FAIL midrst_acc_out: got %0d want 0", acc_out); end
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    lut_valid = 1'b1;
    lut_in    = planes[5];
    repeat (4) step();
    lut_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_no_result: got %b want 0", out_valid); end
    prep();
    do_start();
    feed(0, 0, 1'b0, WA, 0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || acc_out !== AW'(e)) begin n_errors++; $display("FAIL midrst_rerun: got %0d want %0d", acc_out, e); end
    handshake();
  endtask

  task automatic test_width1();
    start_1     = 1'b1;
    offset_in_1 = AW1'(-3);
    step();
    start_1     = 1'b0;
    lut_valid_1 = 1'b1;
    lut_in_1    = (LW + 1)'(3);
    step();
    lut_valid_1 = 1'b0;
    n_checks += 2;
    if (out_valid_1 !== 1'b1) begin n_errors++; $display("FAIL w1_valid: got %b want 1", out_valid_1); end
    if (acc_out_1 !== AW1'(-6)) begin n_errors++; $display("FAIL w1_value: got %0d want -6", acc_out_1); end
    out_ready_1 = 1'b1;
    step();
    out_ready_1 = 1'b0;
    n_checks++;
    if (out_valid_1 !== 1'b0) begin n_errors++; $display("FAIL w1_valid_drop: got %b want 0", out_valid_1); end
  endtask

  task automatic test_random();
    int lat, e;
    bit to;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < KK; k++) begin
        va[k] = int'($urandom_range(255)) - 128;
        vb[k] = 2 * (int'($urandom_range(127)) - 64);
      end
      prep();
      do_start();
      feed(0, 0, 1'b0, WA, 1);
      wait_valid(lat, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || acc_out !== AW'(e)) begin
        n_errors++;
        $display("FAIL rand_value[%0d]: got %0d want %0d (timeout=%0b)", n, acc_out, e, to);
      end
      repeat ($urandom_range(2)) step();
      handshake();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; lut_valid = 1'b0; out_ready = 1'b0;
    offset_in = '0; lut_in = '0;
    start_1 = 1'b0; lut_valid_1 = 1'b0; out_ready_1 = 1'b0;
    offset_in_1 = '0; lut_in_1 = '0;
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_backpressure_restart();
    test_reset_mid();
    test_width1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
